// File: rtl/sensor_node_system_if.sv
// rtl/sensor_node_system_if.sv - host-facing UART and LED signal bundle of the sensor node
interface sensor_node_system_if;
  logic uart_rxd;
  logic uart_txd;
  logic led;

  modport slave  (input uart_rxd, output uart_txd, output led);
  modport master (output uart_rxd, input uart_txd, input led);
endinterface

// File: rtl/sensor_node_system.sv
// rtl/sensor_node_system.sv - GPIO sensor node: change reports and host commands over 8N1 UART
module sensor_node_system #(
  parameter int clk_freq       = 100000000,
  parameter int uart_baud_rate = 115200
) (
  input  logic                 clk,
  input  logic                 rst,
  sensor_node_system_if.slave  bus,
  inout  wire  [7:0]           gpio_io
);

  localparam int DIV = clk_freq / uart_baud_rate;
  localparam int CW  = $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

  typedef enum logic [1:0] {C_IDLE, C_WAIT_ARG, C_RESPOND} cmd_state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  logic [7:0]    r_dir, r_out, r_gpio_s1, r_gpio_s2, r_last;
  logic          r_led, r_txd, r_tx_busy;
  logic [18:0]   r_tx_shift;
  logic [4:0]    r_tx_left;
  logic [CW-1:0] r_tx_div;
  logic          r_rx_s1, r_rx_s2, r_rx_prev;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift, r_cmd_byte, r_arg;
  logic          r_avail, r_apply;
  logic [1:0]    r_target;
  cmd_state_t    r_cmd, w_cmd_next;
  rx_state_t     r_rx, w_rx_next;
  logic          w_consume, w_load, w_rx_tick, w_rx_done;

  for (genvar gi = 0; gi < 8; gi++) begin : g_pin
    assign gpio_io[gi] = r_dir[gi] ? r_out[gi] : 1'bz;
  end

  assign bus.led      = r_led;
  assign bus.uart_txd = r_txd;

  // A read request and a pending change are served by the same message.
  assign w_load    = !r_tx_busy && ((r_gpio_s2 != r_last) || (r_cmd == C_RESPOND));
  assign w_rx_tick = (r_rx_cnt == '0);
  assign w_rx_done = (r_rx == R_STOP) && w_rx_tick && r_rx_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gpio_s1  <= '0;
      r_gpio_s2  <= '0;
      r_last     <= '0;
      r_txd      <= 1'b1;
      r_tx_busy  <= 1'b0;
      r_tx_shift <= '0;
      r_tx_left  <= '0;
      r_tx_div   <= '0;
    end else begin
      r_gpio_s1 <= gpio_io;
      r_gpio_s2 <= r_gpio_s1;
      if (w_load) begin
        r_last     <= r_gpio_s2;
        r_tx_busy  <= 1'b1;
        r_txd      <= 1'b0;
        r_tx_shift <= {1'b1, r_gpio_s2, 1'b0, 1'b1, 8'h47};
        r_tx_left  <= 5'd19;
        r_tx_div   <= DIV_M1;
      end else if (r_tx_busy) begin
        if (r_tx_div != '0) begin
          r_tx_div <= r_tx_div - 1'b1;
        end else if (r_tx_left == '0) begin
          r_tx_busy <= 1'b0;
          r_txd     <= 1'b1;
        end else begin
          r_txd      <= r_tx_shift[0];
          r_tx_shift <= {1'b0, r_tx_shift[18:1]};
          r_tx_left  <= r_tx_left - 1'b1;
          r_tx_div   <= DIV_M1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rx <= R_IDLE;
    else      r_rx <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx;
    case (r_rx)
      R_IDLE:  if (r_rx_prev && !r_rx_s2) w_rx_next = R_START;
      R_START: if (w_rx_tick) w_rx_next = r_rx_s2 ? R_IDLE : R_DATA;
      R_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = R_STOP;
      R_STOP:  if (w_rx_tick) w_rx_next = R_IDLE;
      default: w_rx_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_s1   <= bus.uart_rxd;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      if (r_rx == R_IDLE) begin
        r_rx_cnt <= HALF_M1;
        r_rx_bit <= '0;
      end else if (w_rx_tick) begin
        r_rx_cnt <= DIV_M1;
        if (r_rx == R_DATA) begin
          r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
          r_rx_bit   <= r_rx_bit + 1'b1;
        end
      end else begin
        r_rx_cnt <= r_rx_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_cmd <= C_IDLE;
    else      r_cmd <= w_cmd_next;
  end

  always_comb begin
    w_cmd_next = r_cmd;
    w_consume  = 1'b0;
    case (r_cmd)
      C_IDLE: if (r_avail) begin
        w_consume = 1'b1;
        case (r_cmd_byte)
          8'h72:               w_cmd_next = C_RESPOND;
          8'h64, 8'h6F, 8'h6C: w_cmd_next = C_WAIT_ARG;
          default:             w_cmd_next = C_IDLE;
        endcase
      end
      C_WAIT_ARG: if (r_avail) begin
        w_consume  = 1'b1;
        w_cmd_next = C_IDLE;
      end
      C_RESPOND: if (w_load) w_cmd_next = C_IDLE;
      default:   w_cmd_next = C_IDLE;
    endcase
  end

  // A byte landing on the consume cycle replaces the consumed one and stays available.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmd_byte <= '0;
      r_avail    <= 1'b0;
      r_target   <= '0;
      r_arg      <= '0;
      r_apply    <= 1'b0;
      r_dir      <= '0;
      r_out      <= '0;
      r_led      <= 1'b0;
    end else begin
      r_apply <= 1'b0;
      if (w_rx_done) begin
        r_cmd_byte <= r_rx_shift;
        r_avail    <= 1'b1;
      end else if (w_consume) begin
        r_avail <= 1'b0;
      end
      if (w_consume && r_cmd == C_IDLE) begin
        r_target <= (r_cmd_byte == 8'h64) ? 2'd0 : (r_cmd_byte == 8'h6F) ? 2'd1 : 2'd2;
      end
      if (w_consume && r_cmd == C_WAIT_ARG) begin
        r_arg   <= r_cmd_byte;
        r_apply <= 1'b1;
      end
      if (r_apply) begin
        case (r_target)
          2'd0:    r_dir <= r_arg;
          2'd1:    r_out <= r_arg;
          default: r_led <= r_arg[0];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sensor_node_system.sv
// tb/tb_sensor_node_system.sv - scoreboard bench for sensor_node_system with a UART host model
`timescale 1ns/1ps
module tb_sensor_node_system;

  localparam int  DIV   = 100000000 / 1152000;
  localparam int  BIT_T = DIV * 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tb_en, tb_val;
  wire  [7:0] gpio_io;

  sensor_node_system_if bus();

  sensor_node_system #(.clk_freq(100000000), .uart_baud_rate(1152000)) dut (
    .clk(clk), .rst(rst), .bus(bus), .gpio_io(gpio_io)
  );

  for (genvar gi = 0; gi < 8; gi++) begin : g_drv
    assign gpio_io[gi] = tb_en[gi] ? tb_val[gi] : 1'bz;
  end

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_pins, model_last;
  int         nbytes = 0;
  time        first_start, second_start, t_rel;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a host sees 'G' + value whenever the pins differ from the last reported value.
  task automatic push_msg(input logic [7:0] v);
    exp_q.push_back(8'h47);
    exp_q.push_back(v);
    model_last = v;
  endtask

  task automatic set_pins(input logic [7:0] v);
    tb_val     = v;
    model_pins = v;
    if (model_pins != model_last) push_msg(model_pins);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    bus.uart_rxd = 1'b0;
    #(BIT_T);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rxd = b[i];
      #(BIT_T);
    end
    bus.uart_rxd = stop;
    #(BIT_T);
    bus.uart_rxd = 1'b1;
    #(BIT_T);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b1);
  endtask

  task automatic wait_idle();
    int cyc   = 0;
    int quiet = 0;
    while (!(exp_q.size() == 0 && quiet >= 3 * DIV) && cyc < 8000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.uart_txd) quiet++;
      else quiet = 0;
    end
    if (cyc >= 8000) check("wait_idle_timeout", exp_q.size(), 0);
  endtask

  initial begin : monitor
    logic [7:0] b;
    logic [7:0] e;
    time        t;
    #20;
    forever begin
      @(negedge bus.uart_txd);
      t = $time;
      #(BIT_T / 2);
      if (bus.uart_txd !== 1'b0) continue;
      for (int i = 0; i < 8; i++) begin
        #(BIT_T);
        b[i] = bus.uart_txd;
      end
      #(BIT_T);
      check("tx_stop_bit", bus.uart_txd, 1);
      if (nbytes == 0) first_start = t;
      if (nbytes == 1) second_start = t;
      nbytes++;
      if (exp_q.size() == 0) begin
        check("tx_unexpected_byte", b, -1);
      end else begin
        e = exp_q.pop_front();
        check("tx_byte", b, e);
      end
    end
  end

  initial begin : stimulus
    logic [7:0] a;
    rst          = 1'b0;
    bus.uart_rxd = 1'b1;
    tb_en        = 8'hFF;
    tb_val       = 8'h01;
    model_pins   = 8'h01;
    model_last   = 8'h00;
    #20;
    check("reset_txd", bus.uart_txd, 1);
    check("reset_led", bus.led, 0);
    set_pins(8'h01);
    #60;
    rst   = 1'b1;
    t_rel = $time;
    wait_idle();
    check("first_start_latency_le_40ns", ((first_start - t_rel) <= 40) ? 1 : 0, 1);
    check("byte_spacing_ns", second_start - first_start, BIT_T * 10);
    check("led_after_report", bus.led, 0);

    for (int k = 0; k < 6; k++) begin
      set_pins(tb_val ^ 8'h01);
      #20000;
    end
    wait_idle();

    set_pins(8'h00);
    repeat (10) @(posedge clk);
    #5000;
    tb_val = 8'h05;
    #3000;
    tb_val     = 8'h07;
    model_pins = 8'h07;
    push_msg(8'h07);
    wait_idle();

    send(8'h6C); send(8'h01); #100;
    check("led_on", bus.led, 1);
    send(8'h6C); send(8'h00); #100;
    check("led_off", bus.led, 0);
    wait_idle();

    for (int k = 0; k < 5; k++) begin
      case ($urandom_range(0, 2))
        0: set_pins(8'($urandom_range(0, 255)));
        1: begin
          a = 8'($urandom);
          send(8'h6C); send(a); #100;
          check("led_random", bus.led, a[0]);
        end
        default: begin
          send(8'h72);
          push_msg(model_pins);
        end
      endcase
      wait_idle();
    end

    set_pins(8'h03);
    wait_idle();
    send(8'h64); send(8'hF0); #100;
    tb_en = 8'h0F;
    send(8'h6F); send(8'hA0);
    model_pins = (8'hA0 & 8'hF0) | (tb_val & 8'h0F);
    push_msg(model_pins);
    wait_idle();
    check("gpio_readback", gpio_io, model_pins);

    send(8'h72);
    push_msg(model_pins);
    wait_idle();

    send(8'h6C); send(8'h01); #100;
    check("led_before_glitch", bus.led, 1);
    send(8'h6C);
    bus.uart_rxd = 1'b0;
    #(BIT_T * 3 / 10);
    bus.uart_rxd = 1'b1;
    #(BIT_T * 2);
    send(8'h00); #100;
    check("led_after_glitch", bus.led, 0);
    send_frame(8'h72, 1'b0);
    wait_idle();
    send(8'h72);
    push_msg(model_pins);
    wait_idle();

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
